// File: rtl/seq_compare_param.sv
// Bit-serial unsigned/two's-complement magnitude comparator with slice-loaded operands.
// Define SEQ_COMPARE_EARLY_EXIT_EN for an MSB-first scan that stops at the first differing bit.
module seq_compare_param #(
  parameter int WIDTH = 8,
  parameter int NIB   = 4,
  parameter int SELW  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIB-1:0]  s,
  input  logic [SELW-1:0] sel,
  input  logic            ld_a,
  input  logic            ld_b,
  input  logic            signed_mode,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            lt,
  output logic            gt,
  output logic            eq
);

  localparam int NSL = WIDTH / NIB;
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             rl_q, rl_d, rg_q, rg_d, re_q, re_d;
  logic             lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             a_bit, b_bit, at_msb, bit_gt, bit_lt;

  // The MSB carries the sign in two's-complement mode, so its sense is inverted.
  always_comb begin
    a_bit  = a_q[cnt_q];
    b_bit  = b_q[cnt_q];
    at_msb = (cnt_q == CNT_LAST);
    bit_gt = a_bit & ~b_bit;
    bit_lt = ~a_bit & b_bit;
    if (mode_q && at_msb) begin
      bit_gt = ~a_bit & b_bit;
      bit_lt = a_bit & ~b_bit;
    end
  end

  // Next-state and datapath
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    rl_d    = rl_q;
    rg_d    = rg_q;
    re_d    = re_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = signed_mode;
          rl_d    = 1'b0;
          rg_d    = 1'b0;
          re_d    = 1'b1;
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
          cnt_d   = CNT_LAST;
`else
          cnt_d   = '0;
`endif
          state_d = RUN;
        end else begin
          // An out-of-range sel matches no slice, so the load is dropped.
          for (int k = 0; k < NSL; k++) begin
            if (sel == SELW'(k)) begin
              if (ld_a) a_d[k*NIB +: NIB] = s;
              if (ld_b) b_d[k*NIB +: NIB] = s;
            end
          end
        end
      end
      RUN: begin
        if (bit_gt) begin
          rl_d = 1'b0;
          rg_d = 1'b1;
          re_d = 1'b0;
        end else if (bit_lt) begin
          rl_d = 1'b1;
          rg_d = 1'b0;
          re_d = 1'b0;
        end
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
        if (bit_gt || bit_lt || cnt_q == '0) state_d = DONE;
        else                                 cnt_d   = cnt_q - 1'b1;
`else
        if (cnt_q == CNT_LAST) state_d = DONE;
        else                   cnt_d   = cnt_q + 1'b1;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs, registered from the next state; results commit on DONE entry.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    lt_d   = lt_q;
    gt_d   = gt_q;
    eq_d   = eq_q;
    if (state_q == RUN && state_d == DONE) begin
      lt_d = rl_d;
      gt_d = rg_d;
      eq_d = re_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      rl_q    <= 1'b0;
      rg_q    <= 1'b0;
      re_q    <= 1'b1;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      rl_q    <= rl_d;
      rg_q    <= rg_d;
      re_q    <= re_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lt   = lt_q;
  assign gt   = gt_q;
  assign eq   = eq_q;

endmodule

// File: tb/tb_seq_compare_param.sv
// Self-checking bench for seq_compare_param: arithmetic reference model plus directed vectors.
module tb_seq_compare_param;
  localparam int WIDTH = 8;
  localparam int NIB   = 4;
  localparam int SELW  = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [NIB-1:0]  s;
  logic [SELW-1:0] sel;
  logic            ld_a, ld_b, signed_mode, start;
  logic            busy, done, lt, gt, eq;

  int checks   = 0;
  int failures = 0;

  seq_compare_param #(.WIDTH(WIDTH), .NIB(NIB), .SELW(SELW)) dut (
    .clk(clk), .reset(reset), .s(s), .sel(sel), .ld_a(ld_a), .ld_b(ld_b),
    .signed_mode(signed_mode), .start(start), .busy(busy), .done(done),
    .lt(lt), .gt(gt), .eq(eq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: operands as plain registers, result from integer compare,
  // timing as a countdown of remaining RUN cycles.
  logic [WIDTH-1:0] m_a, m_b;
  bit               m_busy, m_done, m_lt, m_gt, m_eq, p_lt, p_gt, p_eq, m_valid;
  int               m_left;

  function automatic int latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int lat = WIDTH;
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
    for (int i = 0; i < WIDTH; i++) if (a[i] != b[i]) lat = WIDTH - i;
`endif
    return lat;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_a = '0; m_b = '0; m_busy = 0; m_done = 0; m_left = 0;
      m_lt = 0; m_gt = 0; m_eq = 1; m_valid = 1;
    end else if (m_valid) begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          if (signed_mode) begin
            p_lt = $signed(m_a) < $signed(m_b);
            p_gt = $signed(m_a) > $signed(m_b);
          end else begin
            p_lt = m_a < m_b;
            p_gt = m_a > m_b;
          end
          p_eq   = (m_a == m_b);
          m_left = latency(m_a, m_b);
          m_busy = 1;
        end else if (int'(sel) < WIDTH / NIB) begin
          if (ld_a) m_a[int'(sel)*NIB +: NIB] = s;
          if (ld_b) m_b[int'(sel)*NIB +: NIB] = s;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1; m_lt = p_lt; m_gt = p_gt; m_eq = p_eq;
        end
      end else begin
        m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("lt", lt, m_lt);
      check("gt", gt, m_gt);
      check("eq", eq, m_eq);
      check("onehot", {29'd0, lt, gt, eq} == 32'd1 || {29'd0, lt, gt, eq} == 32'd2
                      || {29'd0, lt, gt, eq} == 32'd4, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit la, input bit lb, input logic [SELW-1:0] sl,
                      input logic [NIB-1:0] v);
    ld_a = la; ld_b = lb; sel = sl; s = v;
    tick();
    ld_a = 0; ld_b = 0;
  endtask

  task automatic run(input bit mode, input bit disturb, output int bc, output int dc);
    signed_mode = mode; start = 1;
    tick();
    start = 0;
    bc = 0; dc = 0;
    if (disturb) begin
      ld_a = 1; sel = 0; s = 4'hF; start = 1;
    end
    for (int n = 0; n < 40 && busy; n++) begin
      bc++;
      if (done) dc++;
      tick();
      ld_a = 0; start = 0;
    end
    if (busy) check("timeout_busy", busy, 0);
  endtask

  int bc, dc;

  initial begin
    reset = 1; s = '0; sel = '0; ld_a = 0; ld_b = 0; signed_mode = 0; start = 0;
    m_valid = 0;
    tick(); tick();
    // 1. reset state
    check("rst_lt", lt, 0); check("rst_gt", gt, 0); check("rst_eq", eq, 1);
    check("rst_busy", busy, 0); check("rst_done", done, 0);
    reset = 0;
    tick();

    // 2. 0x5A vs 0x3C unsigned
    load(1, 0, 0, 4'hA); load(1, 0, 1, 4'h5);
    load(0, 1, 0, 4'hC); load(0, 1, 1, 4'h3);
    run(0, 0, bc, dc);
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
    check("t2_busy_cycles", bc, 3);
`else
    check("t2_busy_cycles", bc, 9);
`endif
    check("t2_done_pulses", dc, 1);
    check("t2_gt", gt, 1); check("t2_lt", lt, 0); check("t2_eq", eq, 0);
    tick();

    // 3. 0x80 vs 0x01, signed then unsigned
    load(1, 0, 0, 4'h0); load(1, 0, 1, 4'h8);
    load(0, 1, 0, 4'h1); load(0, 1, 1, 4'h0);
    run(1, 0, bc, dc);
    check("t3s_lt", lt, 1); check("t3s_gt", gt, 0); check("t3s_done", dc, 1);
    run(0, 0, bc, dc);
    check("t3u_gt", gt, 1); check("t3u_lt", lt, 0);
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
    check("t3u_busy_cycles", bc, 2);
`else
    check("t3u_busy_cycles", bc, 9);
`endif

    // 4. simultaneous ld_a/ld_b -> 0xC3 both
    load(1, 1, 0, 4'h3); load(1, 1, 1, 4'hC);
    run(0, 0, bc, dc);
    check("t4_eq", eq, 1); check("t4_busy_cycles", bc, 9);

    // 5. load and start during RUN are ignored
    run(1, 1, bc, dc);
    check("t5_eq", eq, 1); check("t5_done_pulses", dc, 1); check("t5_busy_cycles", bc, 9);
    tick(); tick();
    check("t5_idle", busy, 0);

    // 6. reset mid-compare
    load(1, 0, 0, 4'h0);
    signed_mode = 0; start = 1;
    tick();
    start = 0;
    tick(); tick(); tick();
    reset = 1;
    tick();
    check("t6_busy", busy, 0); check("t6_eq", eq, 1); check("t6_done", done, 0);
    check("t6_gt", gt, 0);
    reset = 0;
    tick();

    // 0x80 vs 0x00 unsigned: early exit after one RUN cycle when enabled
    load(1, 0, 1, 4'h8);
    run(0, 0, bc, dc);
    check("t7_gt", gt, 1); check("t7_done_pulses", dc, 1);
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
    check("t7_busy_cycles", bc, 2);
`else
    check("t7_busy_cycles", bc, 9);
`endif
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
